clk_rst_ctrl: RTL
=================

Name: clk_rst_ctrl

Overview:
Synthesisable clock/reset controller that sits between the board or bench clock source and the Starfish MCU core. It replaces the free-running, fixed-period clock drive with a managed scheme: a reset stretcher, a RUN/HALT/single-STEP core-enable state machine, NUM_CH parametrised clock-enable dividers, and a saturating cycle counter. All core logic runs on one clock and is gated only through enables. No clock gating is used.

Parameters:
NUM_CH, 2, number of divided clock-enable channels (>=1)
DIV_W, 8, width of each channel divide value
RST_STRETCH, 16, number of clk edges core_rst is held after rst release (>=1)
CYC_W, 32, width of the cycle counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
div  in  NUM_CH*DIV_W  per-channel divide value; channel i uses bits [i*DIV_W +: DIV_W]
run  in  1  level: request free-running execution
halt_req  in  1  level: force HALT from RUN
step  in  1  single-step request; rising edge is detected internally
core_rst  out  1  reset to MCU core, high in RESET state
core_en  out  1  core clock enable
ch_en  out  NUM_CH  divided clock-enable pulses
cycle_count  out  CYC_W  number of enabled core cycles, saturating
state  out  2  current state: RESET=0, HALT=1, RUN=2, STEP=3

Behaviour:
- Async reset while rst=1:
  - state=RESET, stretch counter=0, step_q=0, all channel counters=0, cycle_count=0.
  - core_rst=1, core_en=0, ch_en=0.
  - Takes effect immediately, with no clock edge needed, including mid-RUN or mid-STEP.
- Output decode from the state register (combinational): core_rst=(state==RESET); core_en=(state==RUN)||(state==STEP).
- step_rise = step & ~step_q; step_q <= step every cycle in every state.
- RESET:
  - Stretch counter increments each edge.
  - On the edge where the counter equals RST_STRETCH-1, next state is RUN if run=1, else HALT.
  - core_rst is therefore high for exactly RST_STRETCH edges after rst release.
  - step_rise is ignored in RESET.
- HALT:
  - If step_rise, go to STEP.
  - Else if run=1 and halt_req=0, go to RUN.
  - Else stay in HALT.
  - step_rise has priority over run.
- RUN: if halt_req=1 or run=0, go to HALT next edge; else stay. step_rise in RUN is ignored and consumed.
- STEP: unconditionally go to HALT next edge, giving exactly one core_en cycle per step rising edge. A held step does not repeat.
- Channel i, with cnt_i of DIV_W bits:
  - ch_en[i] = core_en && (cnt_i >= div_i), combinational.
  - On edges with core_en=1: cnt_i <= (cnt_i >= div_i) ? 0 : cnt_i+1.
  - On edges with core_en=0: cnt_i holds.
  - div_i=0 gives ch_en[i]=core_en.
  - Period is div_i+1 enabled cycles.
  - Lowering div_i below cnt_i causes a pulse on the next enabled cycle, then a wrap to 0. This is a defined boundary, not an error.
- cycle_count:
  - Increments by 1 on each edge with core_en=1.
  - Saturates at 2^CYC_W-1; no wrap.
  - Holds in HALT.
  - Cleared only by rst.
- Channel counters and cycle_count freeze during HALT; they are not cleared.

Test Plan:
- RST_STRETCH=4, run=1, release rst: core_rst=1 for 4 edges, then state=2 and core_en=1; cycle_count=3 after 3 further edges.
- div={ch1=2, ch0=0}, RUN for 9 cycles: ch_en[0] high all 9 cycles; ch_en[1] high on enabled cycles 3, 6 and 9 only.
- In RUN, pulse halt_req for 1 cycle with run=1 held: state=1 and core_en=0 on the next edge. cycle_count and cnt_i frozen. With halt_req low again, state returns to RUN the next edge.
- In HALT with run=0, hold step high for 5 cycles: exactly one core_en cycle, state sequence 1,3,1,1,…, cycle_count +1. A second rising edge of step gives exactly one more.
- ch0 div=5 with cnt0=4, change div to 1: ch_en[0] pulses on the next enabled cycle, cnt0 wraps to 0, then pulses every 2nd enabled cycle.
- CYC_W=4, RUN for 20 cycles: cycle_count sticks at 15. Assert rst asynchronously mid-cycle: core_rst=1, core_en=0, cycle_count=0 before the next clk edge.

Source files
------------

// File: rtl/clk_rst_ctrl.sv
// Clock/reset controller for the Starfish MCU core: reset stretcher,
// RUN/HALT/STEP enable FSM, clock-enable dividers and a saturating cycle counter.
module clk_rst_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int RST_STRETCH = 16,
  parameter int CYC_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    run,
  input  logic                    halt_req,
  input  logic                    step,
  output logic                    core_rst,
  output logic                    core_en,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [CYC_W-1:0]        cycle_count,
  output logic [1:0]              state
);

  localparam int SW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
  localparam logic [SW-1:0] STR_LAST = SW'(RST_STRETCH - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HALT  = 2'd1,
    S_RUN   = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [SW-1:0] stretch;
  logic          step_q;
  logic          step_rise;

  assign step_rise = step & ~step_q;
  assign state     = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= S_RESET;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_RESET: begin
        if (stretch == STR_LAST) begin
          nxt = run ? S_RUN : S_HALT;
        end
      end
      S_HALT: begin
        // a step request wins over a pending run request
        if (step_rise) begin
          nxt = S_STEP;
        end else if (run && !halt_req) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req || !run) begin
          nxt = S_HALT;
        end
      end
      S_STEP: begin
        nxt = S_HALT;
      end
      default: nxt = S_RESET;
    endcase
  end

  always_comb begin
    core_rst = (cur == S_RESET);
    core_en  = (cur == S_RUN) || (cur == S_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch <= '0;
    end else if (cur == S_RESET) begin
      stretch <= stretch + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] dv;
    logic             hit;

    assign dv       = div[i*DIV_W +: DIV_W];
    // >= rather than == so a divide value lowered below cnt still wraps
    assign hit      = (cnt >= dv);
    assign ch_en[i] = core_en && hit;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (core_en) begin
        cnt <= hit ? '0 : cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (core_en && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CYC_W'(1);
    end
  end

endmodule
